// File: rtl/operand_loader_pkg.sv
// Shared definitions for the comparator input stage: FSM state encodings and
// default sizing for the operand loader and its key debouncers.
package operand_loader_pkg;

    localparam int DEF_N      = 4;
    localparam int DEF_DB_CNT = 250000;

    typedef enum logic [1:0] {
        ST_WAIT_X = 2'b00,
        ST_WAIT_Y = 2'b01,
        ST_READY  = 2'b10
    } state_t;

endpackage

// File: rtl/operand_loader_key_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low push-button;
// emits a single-cycle press pulse when a 1->0 level is accepted.
module key_debounce
    import operand_loader_pkg::*;
#(
    parameter int DB_CNT = DEF_DB_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic level
);

    localparam int DB_W = $clog2(DB_CNT);
    localparam logic [DB_W-1:0] LAST_COUNT = DB_W'(DB_CNT - 1);

    logic            r_meta;
    logic            r_sync;
    logic            r_level;
    logic [DB_W-1:0] r_count;
    logic            w_differs;
    logic            w_accept;

    assign w_differs = (r_sync != r_level);
    assign w_accept  = w_differs && (r_count == LAST_COUNT);

    // Any sample matching the accepted level restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_level <= 1'b1;
            r_count <= '0;
        end else begin
            r_meta <= key_n;
            r_sync <= r_meta;
            if (w_accept) begin
                r_level <= r_sync;
                r_count <= '0;
            end else if (w_differs) begin
                r_count <= r_count + DB_W'(1);
            end else begin
                r_count <= '0;
            end
        end
    end

    // Combinational so the FSM acts on the same edge the level is accepted.
    assign pressed = w_accept & ~r_sync;
    assign level   = r_level;

endmodule

// File: rtl/operand_loader.sv
// Captures operand x then operand y (with signed mode) from the slide switches
// on debounced button presses and holds them stable for the comparator.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter  int N      = DEF_N,
    parameter  int DB_CNT = DEF_DB_CNT,
    localparam int W      = 2 * N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw,
    input  logic         sw_signed,
    input  logic         key_load_n,
    input  logic         key_clear_n,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         signed_mode,
    output logic         operands_valid,
    output logic         load_strobe,
    output logic [1:0]   state_led
);

    logic [W-1:0] r_swMeta;
    logic [W-1:0] r_swSync;
    logic         r_signedMeta;
    logic         r_signedSync;

    state_t       r_state;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic         r_signed;
    logic         r_valid;
    logic         r_strobe;

    state_t       w_nextState;
    logic [W-1:0] w_nextX;
    logic [W-1:0] w_nextY;
    logic         w_nextSigned;
    logic         w_nextStrobe;
    logic         w_loadEvt;
    logic         w_clearEvt;
    logic         w_unusedLoadLevel;
    logic         w_unusedClearLevel;

    key_debounce #(.DB_CNT(DB_CNT)) u_loadKey (
        .clk     (clk),
        .rst     (rst),
        .key_n   (key_load_n),
        .pressed (w_loadEvt),
        .level   (w_unusedLoadLevel)
    );

    key_debounce #(.DB_CNT(DB_CNT)) u_clearKey (
        .clk     (clk),
        .rst     (rst),
        .key_n   (key_clear_n),
        .pressed (w_clearEvt),
        .level   (w_unusedClearLevel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_swMeta     <= '0;
            r_swSync     <= '0;
            r_signedMeta <= 1'b0;
            r_signedSync <= 1'b0;
        end else begin
            r_swMeta     <= sw;
            r_swSync     <= r_swMeta;
            r_signedMeta <= sw_signed;
            r_signedSync <= r_signedMeta;
        end
    end

    // Clear takes priority; a load arriving on the same edge is dropped.
    always_comb begin
        w_nextState  = r_state;
        w_nextX      = r_x;
        w_nextY      = r_y;
        w_nextSigned = r_signed;
        w_nextStrobe = 1'b0;
        if (w_clearEvt) begin
            w_nextState  = ST_WAIT_X;
            w_nextX      = '0;
            w_nextY      = '0;
            w_nextSigned = 1'b0;
        end else if (w_loadEvt) begin
            case (r_state)
                ST_WAIT_X: begin
                    w_nextX     = r_swSync;
                    w_nextState = ST_WAIT_Y;
                end
                ST_WAIT_Y: begin
                    w_nextY      = r_swSync;
                    w_nextSigned = r_signedSync;
                    w_nextState  = ST_READY;
                    w_nextStrobe = 1'b1;
                end
                ST_READY: begin
                    w_nextX     = r_swSync;
                    w_nextState = ST_WAIT_Y;
                end
                default: begin
                    w_nextState = ST_WAIT_X;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_WAIT_X;
            r_x      <= '0;
            r_y      <= '0;
            r_signed <= 1'b0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_x      <= w_nextX;
            r_y      <= w_nextY;
            r_signed <= w_nextSigned;
            r_valid  <= (w_nextState == ST_READY);
            r_strobe <= w_nextStrobe;
        end
    end

    assign x              = r_x;
    assign y              = r_y;
    assign signed_mode    = r_signed;
    assign operands_valid = r_valid;
    assign load_strobe    = r_strobe;
    assign state_led      = r_state;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a shortened debounce window; expected
// snapshots are queued at stimulus time and checked whenever the FSM moves.
module tb_operand_loader;

    localparam int N   = 4;
    localparam int W   = 2 * N;
    localparam int DB  = 4;
    localparam int LAT = DB + 2;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic         v;
        logic         strb;
        logic [1:0]   st;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw;
    logic         sw_signed;
    logic         key_load_n;
    logic         key_clear_n;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         signed_mode;
    logic         operands_valid;
    logic         load_strobe;
    logic [1:0]   state_led;

    exp_t sb[$];
    exp_t monE;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   monEn = 1'b0;
    logic [1:0] prevState;

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    operand_loader #(.N(N), .DB_CNT(DB)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw             (sw),
        .sw_signed      (sw_signed),
        .key_load_n     (key_load_n),
        .key_clear_n    (key_clear_n),
        .x              (x),
        .y              (y),
        .signed_mode    (signed_mode),
        .operands_valid (operands_valid),
        .load_strobe    (load_strobe),
        .state_led      (state_led)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [W-1:0] ex, input logic [W-1:0] ey, input logic es,
                           input logic ev, input logic estb, input logic [1:0] est, input int ecyc);
        exp_t e;
        e.x = ex; e.y = ey; e.s = es; e.v = ev; e.strb = estb; e.st = est; e.cyc = ecyc;
        sb.push_back(e);
    endtask

    // Press the selected keys on a negedge, hold, release, and let the release settle.
    task automatic applyStimulus(input bit ld, input bit clr,
                                 input logic [W-1:0] ex, input logic [W-1:0] ey, input logic es,
                                 input logic ev, input logic estb, input logic [1:0] est,
                                 input int hold);
        key_load_n  = ~ld;
        key_clear_n = ~clr;
        pushExp(ex, ey, es, ev, estb, est, cyc + LAT);
        repeat (hold) @(negedge clk);
        key_load_n  = 1'b1;
        key_clear_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Every state change or strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (monEn) begin
            if (state_led !== prevState || load_strobe === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_output: got x=%h y=%h s=%b v=%b strb=%b st=%b at cycle %0d, expected no output",
                             x, y, signed_mode, operands_valid, load_strobe, state_led, cyc);
                end else begin
                    monE = sb.pop_front();
                    if ({x, y, signed_mode, operands_valid, load_strobe, state_led} !==
                        {monE.x, monE.y, monE.s, monE.v, monE.strb, monE.st} || cyc != monE.cyc) begin
                        fails++;
                        $display("[TB] FAIL scoreboard: got x=%h y=%h s=%b v=%b strb=%b st=%b cyc=%0d, expected x=%h y=%h s=%b v=%b strb=%b st=%b cyc=%0d",
                                 x, y, signed_mode, operands_valid, load_strobe, state_led, cyc,
                                 monE.x, monE.y, monE.s, monE.v, monE.strb, monE.st, monE.cyc);
                    end
                end
            end
            prevState = state_led;
        end
    end

    initial begin
        int c;
        rst         = 1'b1;
        sw          = '0;
        sw_signed   = 1'b0;
        key_load_n  = 1'b1;
        key_clear_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_x", 32'(x), 32'h0);
        checkOutput("reset_y", 32'(y), 32'h0);
        checkOutput("reset_signed", 32'(signed_mode), 32'h0);
        checkOutput("reset_valid", 32'(operands_valid), 32'h0);
        checkOutput("reset_strobe", 32'(load_strobe), 32'h0);
        checkOutput("reset_state", 32'(state_led), 32'h0);
        rst       = 1'b0;
        prevState = state_led;
        monEn     = 1'b1;
        repeat (5) @(negedge clk);

        sw = 8'h5A;
        key_load_n = 1'b0;
        repeat (3) @(negedge clk);
        key_load_n = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("glitch_state", 32'(state_led), 32'h0);
        checkOutput("glitch_x", 32'(x), 32'h0);

        sw = 8'h82;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'h82, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 100);
        sw = 8'hFF;
        repeat (10) @(negedge clk);
        checkOutput("x_ignores_switches", 32'(x), 32'h82);

        sw = 8'h00;
        sw_signed = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'h82, 8'h00, 1'b1, 1'b1, 1'b1, 2'b10, 10);
        checkOutput("ready_strobe_low", 32'(load_strobe), 32'h0);
        checkOutput("ready_valid", 32'(operands_valid), 32'h1);

        sw = 8'h7F;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 10);

        sw = 8'hA5;
        sw_signed = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'h7F, 8'hA5, 1'b0, 1'b1, 1'b1, 2'b10, 10);

        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 10);

        sw = 8'h3C;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 10);

        sw = 8'hC3;
        repeat (3) @(negedge clk);
        key_load_n = 1'b0;
        c = cyc;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pushExp(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, cyc + 1);
        @(negedge clk);
        rst = 1'b0;
        pushExp(8'hC3, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, c + 4 + LAT);
        repeat (15) @(negedge clk);
        key_load_n = 1'b1;
        repeat (10) @(negedge clk);

        sw = 8'h11;
        sw_signed = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'hC3, 8'h11, 1'b1, 1'b1, 1'b1, 2'b10, 10);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
